version_reporter: RTL and testbench



---
 rtl/version_pkg.sv | 14 +
 rtl/version_report_pkg.sv | 17 +
 rtl/version_reporter.sv | 121 ++++++++++++
 tb/tb_version_reporter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/version_pkg.sv
// Build identity constants, regenerated by the build script.
// Fields other than the version numbers are BCD.
package version_pkg;
  localparam logic [7:0]  C_VERSION_MAJOR  = 8'h00;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'h00;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'h00;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'd77;
  localparam logic [15:0] C_VERSION_YEAR   = 16'h2026;
  localparam logic [7:0]  C_VERSION_MONTH  = 8'h01;
  localparam logic [7:0]  C_VERSION_DAY    = 8'h15;
  localparam logic [7:0]  C_VERSION_HOUR   = 8'h12;
  localparam logic [7:0]  C_VERSION_MINUTE = 8'h15;
  localparam logic [7:0]  C_VERSION_SECOND = 8'h48;
endpackage

// File: rtl/version_report_pkg.sv
// Shared types and framing constants for the
// build-identity report stream.
package version_report_pkg;
  localparam logic [7:0] C_REPORT_HEADER = 8'hA5;
  localparam logic [7:0] C_REPORT_LEN    = 8'h0B;
  localparam int         C_REPORT_BYTES  = 14;

  typedef enum logic {
    IDLE,
    SEND
  } report_state_t;

  typedef logic [3:0] byte_idx_t;

  localparam byte_idx_t C_LAST_IDX =
    byte_idx_t'(C_REPORT_BYTES - 1);
endpackage

// File: rtl/version_reporter.sv
// Streams the build identity as a framed,
// checksummed 14-byte record on a byte link.
module version_reporter
  import version_report_pkg::*;
#(
  parameter logic [7:0]  G_HEADER = C_REPORT_HEADER,
  parameter logic [7:0]  G_MAJOR  =
    version_pkg::C_VERSION_MAJOR,
  parameter logic [7:0]  G_MINOR  =
    version_pkg::C_VERSION_MINOR,
  parameter logic [7:0]  G_PATCH  =
    version_pkg::C_VERSION_PATCH,
  parameter logic [7:0]  G_BUILD  =
    version_pkg::C_VERSION_BUILD,
  parameter logic [15:0] G_YEAR   =
    version_pkg::C_VERSION_YEAR,
  parameter logic [7:0]  G_MONTH  =
    version_pkg::C_VERSION_MONTH,
  parameter logic [7:0]  G_DAY    =
    version_pkg::C_VERSION_DAY,
  parameter logic [7:0]  G_HOUR   =
    version_pkg::C_VERSION_HOUR,
  parameter logic [7:0]  G_MINUTE =
    version_pkg::C_VERSION_MINUTE,
  parameter logic [7:0]  G_SECOND =
    version_pkg::C_VERSION_SECOND
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic [15:0] report_count
);

  report_state_t state;
  byte_idx_t     idx;
  logic [7:0]    acc;

  byte_idx_t     idx_nxt;
  logic [7:0]    acc_nxt;
  logic [7:0]    byte_nxt;

  // Next index, accumulator and the byte it selects;
  // the checksum folds in the byte being accepted now.
  always_comb begin
    idx_nxt = idx + byte_idx_t'(1);
    acc_nxt = acc;
    if (idx != '0 && idx != C_LAST_IDX)
      acc_nxt = acc + m_data;
    unique case (idx_nxt)
      4'd1:    byte_nxt = C_REPORT_LEN;
      4'd2:    byte_nxt = G_MAJOR;
      4'd3:    byte_nxt = G_MINOR;
      4'd4:    byte_nxt = G_PATCH;
      4'd5:    byte_nxt = G_BUILD;
      4'd6:    byte_nxt = G_YEAR[15:8];
      4'd7:    byte_nxt = G_YEAR[7:0];
      4'd8:    byte_nxt = G_MONTH;
      4'd9:    byte_nxt = G_DAY;
      4'd10:   byte_nxt = G_HOUR;
      4'd11:   byte_nxt = G_MINUTE;
      4'd12:   byte_nxt = G_SECOND;
      4'd13:   byte_nxt = 8'h00 - acc_nxt;
      default: byte_nxt = G_HEADER;
    endcase
  end

  // Record FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      report_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= SEND;
            idx       <= '0;
            acc       <= '0;
            m_data    <= G_HEADER;
            m_valid   <= 1'b1;
            m_last    <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          if (m_ready) begin
            if (idx == C_LAST_IDX) begin
              state        <= IDLE;
              m_valid      <= 1'b0;
              m_last       <= 1'b0;
              req_ready    <= 1'b1;
              busy         <= 1'b0;
              report_count <= report_count + 16'd1;
            end else begin
              idx    <= idx_nxt;
              acc    <= acc_nxt;
              m_data <= byte_nxt;
              m_last <= (idx_nxt == C_LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_version_reporter.sv
// Self-checking bench for version_reporter with a
// record-level reference model.
module tb_version_reporter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic [15:0] report_count;

  logic        ready_cmd = 1'b1;
  logic        rand_mode = 1'b0;
  logic        rnd_bit   = 1'b1;

  logic        req2 = 1'b0;
  logic        rdy2_o;
  logic [7:0]  data2;
  logic        valid2;
  logic        last2;
  logic        busy2;
  logic [15:0] count2;

  int errors = 0;
  int checks = 0;

  assign m_ready = rand_mode ? rnd_bit : ready_cmd;

  always #5 clk = ~clk;

  version_reporter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy),
    .report_count (report_count)
  );

  version_reporter #(
    .G_MAJOR  (8'hFF),
    .G_MINOR  (8'hFF),
    .G_PATCH  (8'hFF),
    .G_BUILD  (8'hFF),
    .G_YEAR   (16'hFFFF),
    .G_MONTH  (8'hFF),
    .G_DAY    (8'hFF),
    .G_HOUR   (8'hFF),
    .G_MINUTE (8'hFF),
    .G_SECOND (8'h59)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req2),
    .req_ready    (rdy2_o),
    .m_data       (data2),
    .m_valid      (valid2),
    .m_ready      (1'b1),
    .m_last       (last2),
    .busy         (busy2),
    .report_count (count2)
  );

  // Hand-computed records.
  logic [7:0] exp_def [14] = '{
    8'hA5, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h4D, 8'h20,
    8'h26, 8'h01, 8'h15, 8'h12, 8'h15, 8'h48, 8'hDD};
  logic [7:0] exp_ovr [14] = '{
    8'hA5, 8'h0B, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h59, 8'hA6};

  // Model record built from the field list.
  logic [7:0] rec [14];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  initial begin
    int s;
    rec[0]  = 8'hA5;
    rec[1]  = 8'h0B;
    rec[2]  = version_pkg::C_VERSION_MAJOR;
    rec[3]  = version_pkg::C_VERSION_MINOR;
    rec[4]  = version_pkg::C_VERSION_PATCH;
    rec[5]  = version_pkg::C_VERSION_BUILD;
    rec[6]  = version_pkg::C_VERSION_YEAR[15:8];
    rec[7]  = version_pkg::C_VERSION_YEAR[7:0];
    rec[8]  = version_pkg::C_VERSION_MONTH;
    rec[9]  = version_pkg::C_VERSION_DAY;
    rec[10] = version_pkg::C_VERSION_HOUR;
    rec[11] = version_pkg::C_VERSION_MINUTE;
    rec[12] = version_pkg::C_VERSION_SECOND;
    s = 0;
    for (int i = 1; i <= 12; i++) s += int'(rec[i]);
    rec[13] = 8'((256 - (s % 256)) % 256);
  end

  // Reference model: position within the record.
  logic        mbusy  = 1'b0;
  int          mpos   = 0;
  logic [15:0] mcount = 16'h0000;
  int          cyc    = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mbusy  = 1'b0;
      mpos   = 0;
      mcount = 16'h0000;
    end else if (!mbusy) begin
      if (req_valid) begin
        mbusy = 1'b1;
        mpos  = 0;
      end
    end else if (m_ready) begin
      if (mpos == 13) begin
        mbusy  = 1'b0;
        mcount = mcount + 16'd1;
      end else begin
        mpos++;
      end
    end
  end

  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 99) >= 40);
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("m_valid", {15'd0, m_valid}, {15'd0, mbusy});
    chk("busy", {15'd0, busy}, {15'd0, mbusy});
    chk("req_ready", {15'd0, req_ready},
        {15'd0, !mbusy});
    chk("m_last", {15'd0, m_last},
        {15'd0, mbusy && mpos == 13});
    if (mbusy)
      chk("m_data", {8'd0, m_data}, {8'd0, rec[mpos]});
    chk("report_count", report_count, mcount);
  end

  // Record collector, stall stability, accept log.
  logic [7:0] cur [$];
  int         rec_done = 0;
  int         acc_cyc [$];
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic       prst = 1'b1;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    if (pv && !pr && !prst) begin
      chk("stall_valid", {15'd0, m_valid}, 16'd1);
      chk("stall_data", {8'd0, m_data}, {8'd0, pd});
      chk("stall_last", {15'd0, m_last}, {15'd0, pl});
    end
    if (req_valid && req_ready && !rst)
      acc_cyc.push_back(cyc);
    if (rst) begin
      cur.delete();
    end else if (m_valid && m_ready) begin
      cur.push_back(m_data);
      if (m_last) begin
        chk("rec_len", 16'(cur.size()), 16'd14);
        for (int i = 0; i < 14 && i < cur.size(); i++)
          chk("rec_byte", {8'd0, cur[i]},
              {8'd0, exp_def[i]});
        rec_done++;
        cur.delete();
      end
    end
    pv   = m_valid;
    pr   = m_ready;
    pl   = m_last;
    pd   = m_data;
    prst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target,
                           input int budget);
    int n = 0;
    while (rec_done < target && n < budget) begin
      tick();
      n++;
    end
    chk("record_timeout", 16'(rec_done >= target), 16'd1);
  endtask

  initial begin
    int base;
    int n;
    int s;
    logic [7:0] b2 [$];

    // Model record against the hand-computed one.
    #1;
    for (int i = 0; i < 14; i++)
      chk("model_rec", {8'd0, rec[i]}, {8'd0, exp_def[i]});

    // 1: reset values, then a plain record.
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_ready", {15'd0, req_ready}, 16'd1);
    chk("rst_m_valid", {15'd0, m_valid}, 16'd0);
    chk("rst_m_last", {15'd0, m_last}, 16'd0);
    chk("rst_m_data", {8'd0, m_data}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_count", report_count, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    pulse_req();
    wait_done(1, 40);
    tick();
    chk("t1_count", report_count, 16'd1);

    // 2: random back-pressure.
    rand_mode = 1'b1;
    pulse_req();
    wait_done(2, 200);
    rand_mode = 1'b0;
    tick();
    chk("t2_count", report_count, 16'd2);

    // 3: request held high across records.
    acc_cyc.delete();
    base = rec_done;
    req_valid = 1'b1;
    wait_done(base + 3, 100);
    req_valid = 1'b0;
    tick();
    tick();
    chk("t3_accepts", 16'(acc_cyc.size()), 16'd3);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("t3_spacing",
          16'(acc_cyc[i] - acc_cyc[i-1]), 16'd15);
    chk("t3_count", report_count, 16'd5);

    // 4: reset while stalled at index 7.
    pulse_req();
    n = 0;
    while (!(mbusy && mpos == 7) && n < 30) begin
      tick();
      n++;
    end
    chk("t4_reach7", 16'(mpos), 16'd7);
    ready_cmd = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_cmd = 1'b1;
    @(negedge clk);
    chk("t4_m_valid", {15'd0, m_valid}, 16'd0);
    chk("t4_m_last", {15'd0, m_last}, 16'd0);
    chk("t4_count", report_count, 16'h0000);
    base = rec_done;
    tick();
    pulse_req();
    wait_done(base + 1, 40);
    tick();
    chk("t4_count_after", report_count, 16'd1);

    // 6: counter wrap.
    force dut.report_count = 16'hFFFF;
    mcount = 16'hFFFF;
    tick();
    release dut.report_count;
    tick();
    chk("t6_preload", report_count, 16'hFFFF);
    base = rec_done;
    pulse_req();
    wait_done(base + 1, 40);
    tick();
    chk("t6_wrap", report_count, 16'h0000);

    // 5: overridden fields, checksum closure.
    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (valid2) begin
        b2.push_back(data2);
        chk("t5_last", {15'd0, last2},
            {15'd0, b2.size() == 14});
        if (last2) break;
      end
      n++;
    end
    chk("t5_len", 16'(b2.size()), 16'd14);
    s = 0;
    for (int i = 0; i < b2.size() && i < 14; i++) begin
      chk("t5_byte", {8'd0, b2[i]}, {8'd0, exp_ovr[i]});
      if (i > 0) s += int'(b2[i]);
    end
    chk("t5_sum", 16'(s % 256), 16'd0);
    tick();
    chk("t5_count", count2, 16'd1);
    chk("t5_busy", {15'd0, busy2}, 16'd0);
    chk("t5_ready", {15'd0, rdy2_o}, 16'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
